// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit feeding a DEPTH-entry result FIFO with valid/ready handshakes on both sides.
// Optional pop counter output oCount is enabled by defining LOGIC_UNIT_PIPE_CNT_EN.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [2:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oResult,
    output logic             oParity,
    output logic             oZero
`ifdef LOGIC_UNIT_PIPE_CNT_EN
    ,
    output logic [15:0]      oCount
`endif
);

    typedef struct packed {
        logic             parity;
        logic             zero;
        logic [WIDTH-1:0] result;
    } entry_t;

    localparam logic [1:0] LAST_PTR  = 2'(DEPTH - 1);
    localparam logic [2:0] DEPTH_CNT = 3'(DEPTH);

    // Storage is sized for the largest legal DEPTH so a 2-bit pointer always indexes exactly.
    entry_t     mem_q [4];
    entry_t     mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] op_result;
    entry_t           new_entry;
    entry_t           head;

    always_comb begin
        op_result = iA;
        case (iOp)
            3'b000:  op_result = iA & iB;
            3'b001:  op_result = iA | iB;
            3'b010:  op_result = ~iA;
            3'b011:  op_result = iA ^ iB;
            3'b100:  op_result = ~(iA & iB);
            3'b101:  op_result = ~(iA | iB);
            3'b110:  op_result = ~(iA ^ iB);
            default: op_result = iA;
        endcase
    end

    assign new_entry.parity = ^op_result;
    assign new_entry.zero   = (op_result == '0);
    assign new_entry.result = op_result;

    // Handshake flags depend only on the registered count, never on iReady.
    assign oReady = (count_q < DEPTH_CNT);
    assign oValid = (count_q != 3'd0);
    assign push   = iValid && oReady;
    assign pop    = oValid && iReady;

    assign head    = mem_q[rd_ptr_q];
    assign oResult = head.result;
    assign oParity = head.parity;
    assign oZero   = head.zero;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? 2'd0 : rd_ptr_q + 2'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Clearing the storage makes the empty head read as result 0 / parity 0 / zero 1 after reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i].parity <= 1'b0;
                mem_q[i].zero   <= 1'b1;
                mem_q[i].result <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef LOGIC_UNIT_PIPE_CNT_EN
    logic [15:0] pop_count_q, pop_count_d;

    always_comb begin
        pop_count_d = pop_count_q;
        if (pop) begin
            pop_count_d = pop_count_q + 16'd1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            pop_count_q <= 16'd0;
        end else begin
            pop_count_q <= pop_count_d;
        end
    end

    assign oCount = pop_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: constant vector table, hand-written handshake
// sequences and randomized traffic checked against a queue-based reference model.
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             iClk = 1'b0;
    logic             iRst;
    logic             iValid;
    logic             iReady;
    logic [2:0]       iOp;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oReady;
    logic             oValid;
    logic [WIDTH-1:0] oResult;
    logic             oParity;
    logic             oZero;
`ifdef LOGIC_UNIT_PIPE_CNT_EN
    logic [15:0]      oCount;
`endif

    logic_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iValid  (iValid),
        .oReady  (oReady),
        .iOp     (iOp),
        .iA      (iA),
        .iB      (iB),
        .oValid  (oValid),
        .iReady  (iReady),
        .oResult (oResult),
        .oParity (oParity),
        .oZero   (oZero)
`ifdef LOGIC_UNIT_PIPE_CNT_EN
        ,
        .oCount  (oCount)
`endif
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             parity;
        logic             zero;
    } entry_t;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] expResult;
        logic             expParity;
        logic             expZero;
    } vector_t;

    int     checksTotal  = 0;
    int     checksPassed = 0;
    entry_t modelQ[$];
    logic   freshReset   = 1'b0;
    int     modelPops    = 0;
    logic   lastAccepted;
    logic   lastPopped;

    // Reference operation from the opcode table, parity via bit counting.
    function automatic entry_t refEntry(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
        entry_t e;
        logic [WIDTH-1:0] r;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~a;
            3'd3: r = a ^ b;
            3'd4: r = ~(a & b);
            3'd5: r = ~(a | b);
            3'd6: r = ~(a ^ b);
            default: r = a;
        endcase
        e.result = r;
        e.parity = ($countones(r) % 2) == 1;
        e.zero   = (r == 0);
        return e;
    endfunction

    task automatic checkOne(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkOne("oValid", 64'(oValid), 64'(modelQ.size() != 0));
        checkOne("oReady", 64'(oReady), 64'(modelQ.size() < DEPTH));
        if (modelQ.size() != 0) begin
            checkOne("oResult", 64'(oResult), 64'(modelQ[0].result));
            checkOne("oParity", 64'(oParity), 64'(modelQ[0].parity));
            checkOne("oZero",   64'(oZero),   64'(modelQ[0].zero));
        end else if (freshReset) begin
            checkOne("rstResult", 64'(oResult), 64'd0);
            checkOne("rstParity", 64'(oParity), 64'd0);
            checkOne("rstZero",   64'(oZero),   64'd1);
        end
`ifdef LOGIC_UNIT_PIPE_CNT_EN
        checkOne("oCount", 64'(oCount), 64'(modelPops % 65536));
`endif
    endtask

    // Drives one cycle from a negedge, advances the model at the posedge, checks at the next negedge.
    task automatic applyStimulus(input logic rst, input logic valid, input logic [2:0] op,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ready);
        iRst   = rst;
        iValid = valid;
        iOp    = op;
        iA     = a;
        iB     = b;
        iReady = ready;
        lastAccepted = !rst && valid && (modelQ.size() < DEPTH);
        lastPopped   = !rst && ready && (modelQ.size() != 0);
        @(posedge iClk);
        if (rst) begin
            modelQ.delete();
            freshReset = 1'b1;
            modelPops  = 0;
        end else begin
            if (lastPopped) begin
                void'(modelQ.pop_front());
                modelPops++;
            end
            if (lastAccepted) begin
                modelQ.push_back(refEntry(op, a, b));
                freshReset = 1'b0;
            end
        end
        @(negedge iClk);
        checkOutput();
    endtask

    vector_t vectors[12];

    initial begin
        vectors[0]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vectors[1]  = '{3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0};
        vectors[2]  = '{3'd2, 8'hF0, 8'h3C, 8'h0F, 1'b0, 1'b0};
        vectors[3]  = '{3'd3, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0};
        vectors[4]  = '{3'd4, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0};
        vectors[5]  = '{3'd5, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0};
        vectors[6]  = '{3'd6, 8'hF0, 8'h3C, 8'h33, 1'b0, 1'b0};
        vectors[7]  = '{3'd7, 8'hF0, 8'h3C, 8'hF0, 1'b0, 1'b0};
        vectors[8]  = '{3'd0, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1};
        vectors[9]  = '{3'd3, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
        vectors[10] = '{3'd7, 8'h01, 8'h00, 8'h01, 1'b1, 1'b0};
        vectors[11] = '{3'd1, 8'h80, 8'h06, 8'h86, 1'b1, 1'b0};

        iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iOp = 3'd0; iA = '0; iB = '0;
        @(negedge iClk);
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        checkOne("resetValid", 64'(oValid), 64'd0);
        checkOne("resetReady", 64'(oReady), 64'd1);

        // Streamed vector table: each result is at the head one cycle after its accept.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, vectors[i].op, vectors[i].a, vectors[i].b, 1'b1);
            checkOne($sformatf("vecResult%0d", i), 64'(oResult), 64'(vectors[i].expResult));
            checkOne($sformatf("vecParity%0d", i), 64'(oParity), 64'(vectors[i].expParity));
            checkOne($sformatf("vecZero%0d", i),   64'(oZero),   64'(vectors[i].expZero));
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

        // Backpressure: two accepted, third held until space frees.
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd0, 8'hF0, 8'h3C, 1'b0);
        checkOne("bpReady1", 64'(oReady), 64'd1);
        applyStimulus(1'b0, 1'b1, 3'd1, 8'hF0, 8'h3C, 1'b0);
        checkOne("bpReadyFull", 64'(oReady), 64'd0);
        applyStimulus(1'b0, 1'b1, 3'd3, 8'hF0, 8'h3C, 1'b0);
        checkOne("bpHeldResult", 64'(oResult), 64'h30);
        applyStimulus(1'b0, 1'b1, 3'd3, 8'hF0, 8'h3C, 1'b1);
        checkOne("bpSecondHead", 64'(oResult), 64'hFC);
        applyStimulus(1'b0, 1'b1, 3'd3, 8'hF0, 8'h3C, 1'b1);
        checkOne("bpThirdHead", 64'(oResult), 64'hCC);
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        checkOne("bpDrained", 64'(oValid), 64'd0);

        // Full buffer with both sides held active for ten cycles.
        applyStimulus(1'b0, 1'b1, 3'd7, 8'h11, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd7, 8'h22, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd7, 8'(8'h40 + i), 8'h00, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

        // Reset with two entries buffered discards them.
        applyStimulus(1'b0, 1'b1, 3'd7, 8'hA1, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd7, 8'hA2, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd7, 8'hA3, 8'h00, 1'b1);
        checkOne("midRstValid",  64'(oValid),  64'd0);
        checkOne("midRstReady",  64'(oReady),  64'd1);
        checkOne("midRstResult", 64'(oResult), 64'd0);
        applyStimulus(1'b0, 1'b1, 3'd7, 8'h5A, 8'h00, 1'b0);
        checkOne("postRstFirst", 64'(oResult), 64'h5A);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom),
                          8'($urandom), 8'($urandom), 1'($urandom));
        end

`ifdef LOGIC_UNIT_PIPE_CNT_EN
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 70000 && modelPops < 65537; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd7, 8'h01, 8'h00, 1'b1);
        end
        checkOne("popBudget", 64'(modelPops), 64'd65537);
        checkOne("countWrap", 64'(oCount), 64'd1);
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        checkOne("countRst", 64'(oCount), 64'd0);
`endif

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
